uni_shift_reg: RTL and testbench
================================

Name: uni_shift_reg

Overview:
- Parameterized n-bit universal shift register: hold, parallel load, shift left, shift right.
- The operation is selected per clock by a 2-bit mode input. Each shift direction has its own serial fill bit.
- General-purpose datapath leaf block. Single clock domain, registered output, no handshake.

Parameters:
- n, default 3, register width in bits. Legal values are n >= 1.

Ports:
- clock  input  1  rising-edge clock for all state.
- clear  input  1  synchronous, active-low reset. It is sampled only on the rising edge of clock. 0 = clear.
- sel  input  2  operation select, sampled at the rising edge.
- in  input  n  parallel load data.
- left_in  input  1  serial bit shifted into the MSB on a right shift.
- right_in  input  1  serial bit shifted into the LSB on a left shift.
- out  output  n  register contents, driven directly from the flops.

Behaviour:
- All updates occur on the rising edge of clock. No asynchronous paths.
- out changes one cycle after the controlling inputs are sampled. No combinational path from any input to out.
- Priority: clear over sel. If clear==0 at the edge, out <= 0 regardless of sel, in, left_in and right_in.
- Reset value: out = all zeros. There is no power-on value other than through clear.
- With clear==1:
  - sel=00 HOLD: out <= out. in, left_in and right_in are ignored.
  - sel=01 LOAD: out <= in.
  - sel=10 SHIFT LEFT (toward MSB): out <= {out[n-2:0], right_in}. The old MSB is discarded.
  - sel=11 SHIFT RIGHT (toward LSB): out <= {left_in, out[n-1:1]}. The old LSB is discarded.
- n==1: shift left gives out <= right_in; shift right gives out <= left_in.
- Serial inputs matter only in their own shift mode:
  - left_in is ignored for sel!=11.
  - right_in is ignored for sel!=10.
- A shift is not a rotate. Bits shifted out are lost, and no carry/serial-out port exists.
- clear asserted in the middle of a shift sequence clears on that edge. The next operation after clear deasserts acts on the zero value.
- Back-to-back mode changes take effect on consecutive edges with no bubble.
- All sel codes are defined, so there is no illegal state. X on sel is not required to be handled.

Decomposition:
- Shared package holds:
  - the sel encoding constants: SEL_HOLD=2'b00, SEL_LOAD=2'b01, SEL_SHL=2'b10, SEL_SHR=2'b11;
  - a 2-bit typedef for the mode.
- One optional sub-module, usr_next_state: purely combinational next-value mux (sel, out, in, left_in, right_in -> next). The top-level uni_shift_reg instantiates it and holds only the register and the clear logic.

Test Plan (n=3):
- Reset: clear=0 for one edge with sel=01, in=111 -> out=000 (clear beats load).
- Load then hold:
  - clear=1, sel=01, in=010 -> out=010 after one edge.
  - Then sel=00 with in=101, left_in=1, right_in=1 for 3 edges -> out stays 010.
- Shift left fill:
  - From 000, sel=10, right_in=1 -> 001, 011, 111 on successive edges.
  - Then right_in=0 -> 110.
- Shift right fill:
  - From 001, sel=11, left_in=1 -> 100.
  - Load 110, then sel=11, left_in=0 -> 011, then 001.
- MSB/LSB loss:
  - Load 101, sel=10, right_in=0 -> 010.
  - Load 101, sel=11, left_in=0 -> 010.
- Mid-sequence clear: load 111, sel=10 for 1 edge -> 110. Then clear=0 for 1 edge -> 000. Then clear=1, sel=10, right_in=1 -> 001.

Source files
------------

// File: rtl/uni_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// uni_shift_reg_pkg
// Shared definitions for the universal shift register.
//   usr_mode_e : 2-bit operation select encoding carried on the sel port.
//     SEL_HOLD  keep current contents
//     SEL_LOAD  parallel load
//     SEL_SHL   shift toward MSB, LSB filled from right_in
//     SEL_SHR   shift toward LSB, MSB filled from left_in
// -----------------------------------------------------------------------------
package uni_shift_reg_pkg;

   typedef enum logic [1:0] {
      SEL_HOLD = 2'b00,
      SEL_LOAD = 2'b01,
      SEL_SHL  = 2'b10,
      SEL_SHR  = 2'b11
   } usr_mode_e;

endpackage : uni_shift_reg_pkg

// File: rtl/uni_shift_reg_next_state.sv
// -----------------------------------------------------------------------------
// usr_next_state
// Purely combinational next-value selector for uni_shift_reg.
// Ports:
//   sel_i      operation select (usr_mode_e encoding)
//   cur_i      current register contents
//   in_i       parallel load data
//   left_in_i  serial fill for the MSB on a right shift
//   right_in_i serial fill for the LSB on a left shift
//   next_o     value the register takes on the next edge
// -----------------------------------------------------------------------------
module usr_next_state
   import uni_shift_reg_pkg::*;
#(
   parameter int n = 3
) (
   input  logic [1:0]   sel_i,
   input  logic [n-1:0] cur_i,
   input  logic [n-1:0] in_i,
   input  logic         left_in_i,
   input  logic         right_in_i,
   output logic [n-1:0] next_o
);

   logic [n-1:0] shl;
   logic [n-1:0] shr;

   // A one-bit register has no bits to carry across, so a shift is just the fill bit.
   generate
      if (n == 1) begin : g_narrow
         assign shl = right_in_i;
         assign shr = left_in_i;
      end else begin : g_wide
         assign shl = {cur_i[n-2:0], right_in_i};
         assign shr = {left_in_i, cur_i[n-1:1]};
      end
   endgenerate

   always_comb begin
      next_o = cur_i;
      case (usr_mode_e'(sel_i))
         SEL_HOLD: next_o = cur_i;
         SEL_LOAD: next_o = in_i;
         SEL_SHL:  next_o = shl;
         SEL_SHR:  next_o = shr;
         default:  next_o = cur_i;
      endcase
   end

endmodule : usr_next_state

// File: rtl/uni_shift_reg.sv
// -----------------------------------------------------------------------------
// uni_shift_reg
// n-bit universal shift register: hold, parallel load, shift left, shift right.
// Ports:
//   clock     rising-edge clock for all state
//   clear     synchronous active-low clear, has priority over sel
//   sel       operation select (uni_shift_reg_pkg::usr_mode_e encoding)
//   in        parallel load data
//   left_in   serial bit entering the MSB on a right shift
//   right_in  serial bit entering the LSB on a left shift
//   out       register contents, straight from the flops
// -----------------------------------------------------------------------------
module uni_shift_reg
   import uni_shift_reg_pkg::*;
#(
   parameter int n = 3
) (
   input  logic         clock,
   input  logic         clear,
   input  logic [1:0]   sel,
   input  logic [n-1:0] in,
   input  logic         left_in,
   input  logic         right_in,
   output logic [n-1:0] out
);

   logic [n-1:0] out_q;
   logic [n-1:0] out_d;

   usr_next_state #(
      .n (n)
   ) u_next (
      .sel_i      (sel),
      .cur_i      (out_q),
      .in_i       (in),
      .left_in_i  (left_in),
      .right_in_i (right_in),
      .next_o     (out_d)
   );

   always_ff @(posedge clock) begin
      if (!clear) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule : uni_shift_reg

// File: tb/tb_uni_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_uni_shift_reg
// Scoreboard bench for uni_shift_reg at n=3, with an n=1 instance sharing the
// same stimulus. Expected values are queued when inputs are driven and popped
// after the following rising edge.
// -----------------------------------------------------------------------------
module tb_uni_shift_reg;

   logic       clock = 1'b0;
   logic       clear;
   logic [1:0] sel;
   logic [2:0] in;
   logic       left_in;
   logic       right_in;
   logic [2:0] out;
   logic [0:0] out1;

   logic [2:0] exp_q[$];
   logic [0:0] exp1_q[$];
   logic [0:0] m1;
   logic [2:0] mdl;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   uni_shift_reg #(.n(3)) dut (
      .clock    (clock),
      .clear    (clear),
      .sel      (sel),
      .in       (in),
      .left_in  (left_in),
      .right_in (right_in),
      .out      (out)
   );

   uni_shift_reg #(.n(1)) dut1 (
      .clock    (clock),
      .clear    (clear),
      .sel      (sel),
      .in       (in[0:0]),
      .left_in  (left_in),
      .right_in (right_in),
      .out      (out1)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   // Independent one-bit reference: load takes in[0], shifts take the fill bit.
   function automatic logic [0:0] model1(input logic [0:0] cur, input logic clr,
                                         input logic [1:0] s, input logic d,
                                         input logic li, input logic ri);
      if (!clr)          return 1'b0;
      else if (s == 2'b01) return d;
      else if (s == 2'b10) return ri;
      else if (s == 2'b11) return li;
      else               return cur;
   endfunction

   task automatic apply(input string tag, input logic clr, input logic [1:0] s,
                        input logic [2:0] d, input logic li, input logic ri,
                        input logic [2:0] exp);
      logic [2:0] e;
      logic [0:0] e1;
      @(negedge clock);
      clear    = clr;
      sel      = s;
      in       = d;
      left_in  = li;
      right_in = ri;
      exp_q.push_back(exp);
      m1 = model1(m1, clr, s, d[0], li, ri);
      exp1_q.push_back(m1);
      @(posedge clock);
      #1;
      e  = exp_q.pop_front();
      e1 = exp1_q.pop_front();
      chk(tag, out, e);
      chk({tag, "_n1"}, {2'b00, out1}, {2'b00, e1});
   endtask

   initial begin
      clear = 1'b1; sel = 2'b00; in = '0; left_in = 1'b0; right_in = 1'b0;
      m1 = 1'b0;

      // Reset beats load
      apply("rst",       1'b0, 2'b01, 3'b111, 1'b0, 1'b0, 3'b000);
      // Load then hold with noisy inputs
      apply("load010",   1'b1, 2'b01, 3'b010, 1'b0, 1'b0, 3'b010);
      for (int i = 0; i < 3; i++)
         apply("hold",   1'b1, 2'b00, 3'b101, 1'b1, 1'b1, 3'b010);
      // Shift-left fill from zero; left_in set to show it is ignored
      apply("clr0",      1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 3'b000);
      apply("shl1",      1'b1, 2'b10, 3'b101, 1'b1, 1'b1, 3'b001);
      apply("shl2",      1'b1, 2'b10, 3'b101, 1'b1, 1'b1, 3'b011);
      apply("shl3",      1'b1, 2'b10, 3'b101, 1'b1, 1'b1, 3'b111);
      apply("shl0",      1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 3'b110);
      // Shift-right fill; right_in set to show it is ignored
      apply("load001",   1'b1, 2'b01, 3'b001, 1'b0, 1'b0, 3'b001);
      apply("shr1",      1'b1, 2'b11, 3'b000, 1'b1, 1'b1, 3'b100);
      apply("load110",   1'b1, 2'b01, 3'b110, 1'b0, 1'b0, 3'b110);
      apply("shr0a",     1'b1, 2'b11, 3'b000, 1'b0, 1'b1, 3'b011);
      apply("shr0b",     1'b1, 2'b11, 3'b000, 1'b0, 1'b1, 3'b001);
      // MSB / LSB loss
      apply("load101a",  1'b1, 2'b01, 3'b101, 1'b0, 1'b0, 3'b101);
      apply("msbloss",   1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 3'b010);
      apply("load101b",  1'b1, 2'b01, 3'b101, 1'b0, 1'b0, 3'b101);
      apply("lsbloss",   1'b1, 2'b11, 3'b000, 1'b0, 1'b0, 3'b010);
      // Mid-sequence clear
      apply("load111",   1'b1, 2'b01, 3'b111, 1'b0, 1'b0, 3'b111);
      apply("shlmid",    1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 3'b110);
      apply("midclr",    1'b0, 2'b10, 3'b111, 1'b1, 1'b1, 3'b000);
      apply("afterclr",  1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 3'b001);

      // Random phase against a behavioural model
      mdl = 3'b001;
      for (int i = 0; i < 200; i++) begin
         logic       c, li, ri;
         logic [1:0] s;
         logic [2:0] d;
         c  = ($urandom_range(0, 15) != 0);
         s  = 2'($urandom_range(0, 3));
         d  = 3'($urandom_range(0, 7));
         li = 1'($urandom_range(0, 1));
         ri = 1'($urandom_range(0, 1));
         if (!c)              mdl = 3'b000;
         else if (s == 2'b01) mdl = d;
         else if (s == 2'b10) mdl = {mdl[1], mdl[0], ri};
         else if (s == 2'b11) mdl = {li, mdl[2], mdl[1]};
         apply($sformatf("rnd%0d", i), c, s, d, li, ri, mdl);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_uni_shift_reg
